fetch_unit: RTL

- Instruction fetch stage of the ONC-16 CPU, directly upstream of the instruction decoder.
- Holds the PC and issues word-addressed reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions in a 2-entry queue (output slot + skid slot) so decode stalls never drop an instruction.
- Handles branch redirects by flushing all buffered and in-flight fetches.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 118 +++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus decoder-facing output.
// Handshake: an instruction moves to decode in any cycle with inst_valid=1 and stall=0; while
// inst_valid=1 and stall=1 the fetch side holds inst/inst_pc stable. stall acts as an inverted ready.
interface fetch_unit_if #(
  parameter int INST_W = 16,
  parameter int ADDR_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;

  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid,
    input  imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_valid,
    output imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// ONC-16 instruction fetch: PC, 1-cycle-latency memory reads, 2-entry output queue
// (output slot + skid slot) and branch-redirect flush.
module fetch_unit #(
  parameter int                INST_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;

  logic              out_v;
  logic [INST_W-1:0] inst_q;
  logic [ADDR_W-1:0] inst_pc_q;

  logic              skid_v;
  logic [INST_W-1:0] skid_inst;
  logic [ADDR_W-1:0] skid_pc;

  logic              deq;
  logic [2:0]        occ_next;
  logic              issue;

  logic              out_v_n;
  logic [INST_W-1:0] out_inst_n;
  logic [ADDR_W-1:0] out_pc_n;
  logic              skid_v_n;
  logic [INST_W-1:0] skid_inst_n;
  logic [ADDR_W-1:0] skid_pc_n;

  // Occupancy counts the in-flight read as already queued, so a new read is only
  // issued when its data is guaranteed a free slot on return.
  assign deq      = out_v & ~bus.stall;
  assign occ_next = 3'(out_v) + 3'(skid_v) + 3'(inflight) - 3'(deq);
  assign issue    = (occ_next < 3'd2);

  assign bus.imem_req   = rst_n & (bus.redirect | issue);
  assign bus.imem_addr  = bus.redirect ? bus.redirect_pc : pc;

  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = out_v;

  // Queue update without redirect: skid advances first, then the response lands
  // in the first free slot, so program order is kept.
  always_comb begin
    out_v_n     = out_v;
    out_inst_n  = inst_q;
    out_pc_n    = inst_pc_q;
    skid_v_n    = skid_v;
    skid_inst_n = skid_inst;
    skid_pc_n   = skid_pc;

    if (deq) begin
      if (skid_v) begin
        out_v_n    = 1'b1;
        out_inst_n = skid_inst;
        out_pc_n   = skid_pc;
        skid_v_n   = 1'b0;
      end else begin
        out_v_n    = 1'b0;
      end
    end

    if (inflight) begin
      if (!out_v_n) begin
        out_v_n    = 1'b1;
        out_inst_n = bus.imem_rdata;
        out_pc_n   = inflight_pc;
      end else begin
        skid_v_n    = 1'b1;
        skid_inst_n = bus.imem_rdata;
        skid_pc_n   = inflight_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      out_v       <= 1'b0;
      inst_q      <= '0;
      inst_pc_q   <= '0;
      skid_v      <= 1'b0;
      skid_inst   <= '0;
      skid_pc     <= '0;
    end else if (bus.redirect) begin
      // The target read is issued this cycle; anything buffered or returning now is stale.
      pc          <= bus.redirect_pc + ADDR_W'(1);
      inflight    <= 1'b1;
      inflight_pc <= bus.redirect_pc;
      out_v       <= 1'b0;
      skid_v      <= 1'b0;
    end else begin
      if (issue) begin
        pc          <= pc + ADDR_W'(1);
        inflight    <= 1'b1;
        inflight_pc <= pc;
      end else begin
        inflight    <= 1'b0;
      end
      out_v     <= out_v_n;
      inst_q    <= out_inst_n;
      inst_pc_q <= out_pc_n;
      skid_v    <= skid_v_n;
      skid_inst <= skid_inst_n;
      skid_pc   <= skid_pc_n;
    end
  end

endmodule
